modulation_segment_scheduler: RTL

MODULATION_SEGMENT_SCHEDULER -- requirements
Module: modulation_segment_scheduler

---
 rtl/modulation_segment_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/modulation_segment_scheduler.sv
// rtl/modulation_segment_scheduler.sv - round-robin scheduler sharing one segment-calculation unit
// Optional watchdog on the unit response: define MOD_SCHED_TIMEOUT_EN.
module modulation_segment_scheduler #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NREQ-1:0]                          req,
    input  logic [32*NREQ-1:0]                       req_operand,
    output logic                                     calc_start,
    output logic [31:0]                              calc_operand,
    input  logic                                     calc_valid,
    input  logic [31:0]                              calc_result,
    output logic [NREQ-1:0]                          done,
    output logic [31:0]                              result,
    output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] result_id,
`ifdef MOD_SCHED_TIMEOUT_EN
    output logic                                     timeout_err,
`endif
    output logic                                     busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("modulation_segment_scheduler: unsupported NREQ/TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state, state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] grant_idx;
    logic          grant_found;

`ifdef MOD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          timed_out;
    logic          wait_expired;
    assign wait_expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign timeout_err  = (state == ST_DONE) && timed_out;
`endif

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        logic [IW-1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IW'(k);
            if (req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        calc_start = 1'b0;
        busy       = 1'b1;
        done       = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (grant_found) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                calc_start = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (calc_valid) state_next = ST_DONE;
`ifdef MOD_SCHED_TIMEOUT_EN
                else if (wait_expired) state_next = ST_DONE;
`endif
            end
            ST_DONE: begin
                done[winner] = 1'b1;
                state_next   = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr          <= '0;
            winner       <= '0;
            calc_operand <= '0;
            result       <= '0;
            result_id    <= '0;
`ifdef MOD_SCHED_TIMEOUT_EN
            wait_cnt     <= '0;
            timed_out    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        winner       <= grant_idx;
                        calc_operand <= req_operand[{grant_idx, 5'b0} +: 32];
                    end
`ifdef MOD_SCHED_TIMEOUT_EN
                    timed_out <= 1'b0;
`endif
                end
                ST_ISSUE: begin
`ifdef MOD_SCHED_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (calc_valid) begin
                        result    <= calc_result;
                        result_id <= winner;
                    end
`ifdef MOD_SCHED_TIMEOUT_EN
                    else if (wait_expired) begin
                        result    <= '0;
                        result_id <= winner;
                        timed_out <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: ptr <= winner + IW'(1);
                default: ;
            endcase
        end
    end
endmodule
